// File: rtl/qmax_update_ctrl.sv
// Q-max table update/lookup controller: clears the table, then serialises max-updates and lookups.
// Optional write statistics counter enabled by defining QMAX_WR_STATS_EN.
module qmax_update_ctrl #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_upd_valid,
  output logic                  o_upd_ready,
  input  logic [ADDR_WIDTH-1:0] i_upd_addr,
  input  logic [DATA_WIDTH-1:0] i_upd_q,
  input  logic                  i_lkp_valid,
  output logic                  o_lkp_ready,
  input  logic [ADDR_WIDTH-1:0] i_lkp_addr,
  output logic                  o_lkp_valid,
  output logic [DATA_WIDTH-1:0] o_lkp_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr_r,
  output logic [ADDR_WIDTH-1:0] o_mem_addr_w,
  output logic                  o_mem_read_en,
  output logic                  o_mem_write_en,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_init_done,
  output logic                  o_busy
`ifdef QMAX_WR_STATS_EN
  ,
  output logic [15:0]           o_wr_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {StInit, StIdle, StUrd, StUcmp, StLrd, StLrsp} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic [DATA_WIDTH-1:0] lkp_data_q, lkp_data_d;
  logic                  lkp_valid_q, lkp_valid_d;
  logic                  init_done_q, init_done_d;
  logic                  rr_lkp_q, rr_lkp_d;
  logic                  idle, upd_ready, lkp_ready, upd_grant, lkp_grant, improve;
  logic                  mem_read_en, mem_write_en;
  logic [ADDR_WIDTH-1:0] mem_addr_w;
  logic [DATA_WIDTH-1:0] mem_data;

  // Arbiter: a lone requester always wins; on contention rr_lkp_q picks the channel.
  always_comb begin
    idle      = (state_q == StIdle) && !i_rst;
    upd_ready = idle && (!i_lkp_valid || !rr_lkp_q);
    lkp_ready = idle && (!i_upd_valid || rr_lkp_q);
    upd_grant = upd_ready && i_upd_valid;
    lkp_grant = lkp_ready && i_lkp_valid;
    improve   = $signed(q_q) > $signed(i_mem_data);
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    addr_d       = addr_q;
    q_d          = q_q;
    lkp_data_d   = lkp_data_q;
    lkp_valid_d  = 1'b0;
    init_done_d  = init_done_q;
    rr_lkp_d     = rr_lkp_q;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr_w   = addr_q;
    mem_data     = q_q;
    unique case (state_q)
      StInit: begin
        mem_write_en = 1'b1;
        mem_addr_w   = init_cnt_q;
        mem_data     = '0;
        init_cnt_d   = init_cnt_q + 1'b1;
        if (init_cnt_q == LastAddr) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end
      end
      StIdle: begin
        if (lkp_grant) begin
          addr_d  = i_lkp_addr;
          state_d = StLrd;
        end else if (upd_grant) begin
          addr_d  = i_upd_addr;
          q_d     = i_upd_q;
          state_d = StUrd;
        end
        if (i_upd_valid && i_lkp_valid) rr_lkp_d = !rr_lkp_q;
      end
      StUrd: begin
        mem_read_en = 1'b1;
        state_d     = StUcmp;
      end
      StUcmp: begin
        // Strictly greater only: equal values leave the table untouched.
        mem_write_en = improve;
        state_d      = StIdle;
      end
      StLrd: begin
        mem_read_en = 1'b1;
        state_d     = StLrsp;
      end
      StLrsp: begin
        lkp_valid_d = 1'b1;
        lkp_data_d  = i_mem_data;
        state_d     = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      addr_q      <= '0;
      q_q         <= '0;
      lkp_data_q  <= '0;
      lkp_valid_q <= 1'b0;
      init_done_q <= 1'b0;
      rr_lkp_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      addr_q      <= addr_d;
      q_q         <= q_d;
      lkp_data_q  <= lkp_data_d;
      lkp_valid_q <= lkp_valid_d;
      init_done_q <= init_done_d;
      rr_lkp_q    <= rr_lkp_d;
    end
  end

  // Enables are masked during reset so an in-flight write is dropped.
  assign o_mem_read_en  = mem_read_en && !i_rst;
  assign o_mem_write_en = mem_write_en && !i_rst;
  assign o_mem_addr_r   = addr_q;
  assign o_mem_addr_w   = mem_addr_w;
  assign o_mem_data     = mem_data;
  assign o_upd_ready    = upd_ready;
  assign o_lkp_ready    = lkp_ready;
  assign o_lkp_valid    = lkp_valid_q;
  assign o_lkp_data     = lkp_data_q;
  assign o_init_done    = init_done_q;
  assign o_busy         = (state_q != StIdle) || i_rst;

`ifdef QMAX_WR_STATS_EN
  logic [15:0] wr_count_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_count_q <= '0;
    end else if ((state_q == StUcmp) && improve && (wr_count_q != 16'hFFFF)) begin
      wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign o_wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_qmax_update_ctrl.sv
// Directed self-checking bench for qmax_update_ctrl with a behavioural table memory.
// Checks o_wr_count too when built with QMAX_WR_STATS_EN.
module tb_qmax_update_ctrl;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int DEPTH = 64;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_upd_valid = 1'b0;
  logic          o_upd_ready;
  logic [AW-1:0] i_upd_addr = '0;
  logic [DW-1:0] i_upd_q = '0;
  logic          i_lkp_valid = 1'b0;
  logic          o_lkp_ready;
  logic [AW-1:0] i_lkp_addr = '0;
  logic          o_lkp_valid;
  logic [DW-1:0] o_lkp_data;
  logic [AW-1:0] o_mem_addr_r, o_mem_addr_w;
  logic          o_mem_read_en, o_mem_write_en;
  logic [DW-1:0] o_mem_data, i_mem_data;
  logic          o_init_done, o_busy;
`ifdef QMAX_WR_STATS_EN
  logic [15:0]   o_wr_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  qmax_update_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_upd_valid(i_upd_valid), .o_upd_ready(o_upd_ready),
    .i_upd_addr(i_upd_addr), .i_upd_q(i_upd_q),
    .i_lkp_valid(i_lkp_valid), .o_lkp_ready(o_lkp_ready), .i_lkp_addr(i_lkp_addr),
    .o_lkp_valid(o_lkp_valid), .o_lkp_data(o_lkp_data),
    .o_mem_addr_r(o_mem_addr_r), .o_mem_addr_w(o_mem_addr_w),
    .o_mem_read_en(o_mem_read_en), .o_mem_write_en(o_mem_write_en),
    .o_mem_data(o_mem_data), .i_mem_data(i_mem_data),
    .o_init_done(o_init_done), .o_busy(o_busy)
`ifdef QMAX_WR_STATS_EN
    , .o_wr_count(o_wr_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Table memory with one-cycle read latency, plus write/grant/response logs.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] wr_addr_log [$];
  logic [DW-1:0] wr_data_log [$];
  byte           grant_log [$];
  logic [DW-1:0] resp_log [$];
  int            both_en_viol = 0;
  int            ready_busy_viol = 0;

  assign i_mem_data = mem_rdata;

  always @(posedge i_clk) begin
    if (o_mem_write_en) begin
      mem[o_mem_addr_w] <= o_mem_data;
      wr_addr_log.push_back(o_mem_addr_w);
      wr_data_log.push_back(o_mem_data);
    end
    if (o_mem_read_en) mem_rdata <= mem[o_mem_addr_r];
    if (o_mem_read_en && o_mem_write_en) both_en_viol <= both_en_viol + 1;
    if ((o_upd_ready || o_lkp_ready) && o_busy) ready_busy_viol <= ready_busy_viol + 1;
    if (i_lkp_valid && o_lkp_ready) grant_log.push_back(8'h4C);
    if (i_upd_valid && o_upd_ready) grant_log.push_back(8'h55);
  end

  always @(negedge i_clk) if (o_lkp_valid) resp_log.push_back(o_lkp_data);

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    grant_log.delete();
    resp_log.delete();
  endtask

  task automatic wait_init(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge i_clk);
      if (o_init_done) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
  endtask

  task automatic do_update(input logic [AW-1:0] a, input logic [DW-1:0] q, output bit ok);
    bit idle_ok;
    @(negedge i_clk);
    i_upd_valid = 1'b1;
    i_upd_addr  = a;
    i_upd_q     = q;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (o_upd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_upd_valid = 1'b0;
    wait_idle(idle_ok);
    ok = ok && idle_ok;
  endtask

  task automatic do_lookup(input logic [AW-1:0] a, output bit ok, output int lat,
                           output logic [DW-1:0] data);
    @(negedge i_clk);
    i_lkp_valid = 1'b1;
    i_lkp_addr  = a;
    ok   = 1'b0;
    lat  = -1;
    data = 'x;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (o_lkp_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    @(posedge i_clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge i_clk);
      if (n == 1) i_lkp_valid = 1'b0;
      if (o_lkp_valid) begin
        lat  = n;
        data = o_lkp_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cycles;
    int bad_seq;
    repeat (3) @(negedge i_clk);
    n_cmp += 8;
    if (o_upd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_upd_ready got %b want 0", o_upd_ready); end
    if (o_lkp_ready !== 1'b0) begin n_bad++; $display("FAIL rst_lkp_ready got %b want 0", o_lkp_ready); end
    if (o_lkp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_lkp_valid got %b want 0", o_lkp_valid); end
    if (o_lkp_data !== '0) begin n_bad++; $display("FAIL rst_lkp_data got %h want 0", o_lkp_data); end
    if (o_mem_read_en !== 1'b0) begin n_bad++; $display("FAIL rst_read_en got %b want 0", o_mem_read_en); end
    if (o_mem_write_en !== 1'b0) begin n_bad++; $display("FAIL rst_write_en got %b want 0", o_mem_write_en); end
    if (o_init_done !== 1'b0) begin n_bad++; $display("FAIL rst_init_done got %b want 0", o_init_done); end
    if (o_busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy got %b want 1", o_busy); end
`ifdef QMAX_WR_STATS_EN
    n_cmp++;
    if (o_wr_count !== 16'd0) begin n_bad++; $display("FAIL rst_wr_count got %0d want 0", o_wr_count); end
`endif
    i_rst = 1'b0;
    clear_logs();
    wait_init(cycles);
    n_cmp++;
    if (cycles != 64) begin n_bad++; $display("FAIL init_cycles got %0d want 64", cycles); end
    n_cmp++;
    if (wr_addr_log.size() != 64) begin
      n_bad++; $display("FAIL init_write_count got %0d want 64", wr_addr_log.size());
    end
    bad_seq = 0;
    for (int i = 0; i < wr_addr_log.size(); i++) begin
      if (wr_addr_log[i] != AW'(i) || wr_data_log[i] != '0) bad_seq++;
    end
    n_cmp++;
    if (bad_seq != 0) begin n_bad++; $display("FAIL init_write_seq got %0d bad want 0", bad_seq); end
    n_cmp += 3;
    if (o_busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", o_busy); end
    if (o_upd_ready !== 1'b1) begin n_bad++; $display("FAIL idle_upd_ready got %b want 1", o_upd_ready); end
    if (o_lkp_ready !== 1'b1) begin n_bad++; $display("FAIL idle_lkp_ready got %b want 1", o_lkp_ready); end
  endtask

  task automatic test_update_lookup();
    bit ok;
    int lat;
    logic [DW-1:0] data;
    clear_logs();
    do_update(6'd5, 32'd10, ok);
    n_cmp += 3;
    if (!ok) begin n_bad++; $display("FAIL upd5_handshake got 0 want 1"); end
    if (wr_addr_log.size() != 1) begin
      n_bad++; $display("FAIL upd5_writes got %0d want 1", wr_addr_log.size());
    end
    if (wr_addr_log[0] !== 6'd5 || wr_data_log[0] !== 32'd10) begin
      n_bad++; $display("FAIL upd5_write got addr %0d data %0d want addr 5 data 10",
                        wr_addr_log[0], wr_data_log[0]);
    end
    do_lookup(6'd5, ok, lat, data);
    n_cmp += 3;
    if (!ok) begin n_bad++; $display("FAIL lkp5_handshake got 0 want 1"); end
    if (lat != 3) begin n_bad++; $display("FAIL lkp5_latency got %0d want 3", lat); end
    if (data !== 32'd10) begin n_bad++; $display("FAIL lkp5_data got %0d want 10", data); end
    @(negedge i_clk);
    n_cmp += 2;
    if (o_lkp_valid !== 1'b0) begin n_bad++; $display("FAIL lkp5_pulse got %b want 0", o_lkp_valid); end
    if (o_lkp_data !== 32'd10) begin n_bad++; $display("FAIL lkp5_hold got %0d want 10", o_lkp_data); end
  endtask

  task automatic test_signed_compare();
    bit ok;
    int lat;
    logic [DW-1:0] data;
    clear_logs();
    do_update(6'd7, 32'd10, ok);
    do_update(6'd7, 32'hFFFF_FFFD, ok);
    do_update(6'd7, 32'd10, ok);
    do_update(6'd8, 32'hFFFF_FFFB, ok);
    n_cmp += 2;
    if (wr_addr_log.size() != 1) begin
      n_bad++; $display("FAIL signed_writes got %0d want 1", wr_addr_log.size());
    end
    if (wr_addr_log[0] !== 6'd7 || wr_data_log[0] !== 32'd10) begin
      n_bad++; $display("FAIL signed_write got addr %0d data %0d want addr 7 data 10",
                        wr_addr_log[0], wr_data_log[0]);
    end
    do_lookup(6'd7, ok, lat, data);
    n_cmp++;
    if (data !== 32'd10) begin n_bad++; $display("FAIL signed_lkp7 got %0d want 10", data); end
    do_lookup(6'd8, ok, lat, data);
    n_cmp++;
    if (data !== 32'd0) begin n_bad++; $display("FAIL signed_lkp8 got %h want 0", data); end
  endtask

  task automatic test_arbitration();
    int cycles;
    bit ok;
    byte exp_g;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    wait_init(cycles);
    clear_logs();
    i_upd_valid = 1'b1;
    i_upd_addr  = 6'd3;
    i_upd_q     = 32'd20;
    i_lkp_valid = 1'b1;
    i_lkp_addr  = 6'd3;
    for (int n = 0; n < 80; n++) begin
      @(negedge i_clk);
      if (grant_log.size() >= 6) break;
    end
    i_upd_valid = 1'b0;
    i_lkp_valid = 1'b0;
    wait_idle(ok);
    repeat (3) @(negedge i_clk);
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 8'h4C : 8'h55;
      n_cmp++;
      if (grant_log[i] !== exp_g) begin
        n_bad++; $display("FAIL arb_grant%0d got %c want %c", i, grant_log[i], exp_g);
      end
    end
    n_cmp += 4;
    if (resp_log.size() != 3) begin n_bad++; $display("FAIL arb_resp_count got %0d want 3", resp_log.size()); end
    if (resp_log[0] !== 32'd0) begin n_bad++; $display("FAIL arb_resp0 got %0d want 0", resp_log[0]); end
    if (resp_log[1] !== 32'd20) begin n_bad++; $display("FAIL arb_resp1 got %0d want 20", resp_log[1]); end
    if (wr_addr_log.size() != 1) begin
      n_bad++; $display("FAIL arb_writes got %0d want 1", wr_addr_log.size());
    end
    n_cmp += 2;
    if (ready_busy_viol != 0) begin n_bad++; $display("FAIL ready_outside_idle got %0d want 0", ready_busy_viol); end
    if (both_en_viol != 0) begin n_bad++; $display("FAIL rd_wr_overlap got %0d want 0", both_en_viol); end
  endtask

  task automatic test_reset_midflight();
    int cycles;
    int bad_seq;
    bit ok;
    int lat;
    logic [DW-1:0] data;
    @(negedge i_clk);
    i_upd_valid = 1'b1;
    i_upd_addr  = 6'd2;
    i_upd_q     = 32'd7;
    #1;
    n_cmp++;
    if (o_upd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_accept got %b want 1", o_upd_ready); end
    @(posedge i_clk);
    @(negedge i_clk);
    i_upd_valid = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_mem_write_en !== 1'b1) begin n_bad++; $display("FAIL mid_ucmp_wr got %b want 1", o_mem_write_en); end
    i_rst = 1'b1;
    clear_logs();
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if (wr_addr_log.size() != 0) begin
      n_bad++; $display("FAIL mid_dropped_write got %0d writes want 0", wr_addr_log.size());
    end
    i_rst = 1'b0;
    repeat (10) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    clear_logs();
    wait_init(cycles);
    n_cmp += 3;
    if (cycles != 64) begin n_bad++; $display("FAIL reinit_cycles got %0d want 64", cycles); end
    if (wr_addr_log.size() != 64) begin
      n_bad++; $display("FAIL reinit_writes got %0d want 64", wr_addr_log.size());
    end
    bad_seq = 0;
    for (int i = 0; i < wr_addr_log.size(); i++) begin
      if (wr_addr_log[i] != AW'(i) || wr_data_log[i] != '0) bad_seq++;
    end
    if (bad_seq != 0) begin n_bad++; $display("FAIL reinit_seq got %0d bad want 0", bad_seq); end
    do_lookup(6'd2, ok, lat, data);
    n_cmp++;
    if (data !== 32'd0) begin n_bad++; $display("FAIL mid_lkp2 got %0d want 0", data); end
  endtask

  task automatic test_wr_stats();
    bit ok;
    int lat;
    logic [DW-1:0] data;
    clear_logs();
    do_update(6'd10, 32'd1, ok);
    do_update(6'd10, 32'd2, ok);
    do_update(6'd10, 32'd5, ok);
    do_update(6'd10, 32'd5, ok);
    do_update(6'd10, 32'hFFFF_FFFF, ok);
    n_cmp++;
    if (wr_addr_log.size() != 3) begin
      n_bad++; $display("FAIL stats_writes got %0d want 3", wr_addr_log.size());
    end
`ifdef QMAX_WR_STATS_EN
    n_cmp++;
    if (o_wr_count !== 16'd3) begin n_bad++; $display("FAIL stats_wr_count got %0d want 3", o_wr_count); end
`endif
    do_lookup(6'd10, ok, lat, data);
    n_cmp++;
    if (data !== 32'd5) begin n_bad++; $display("FAIL stats_lkp10 got %0d want 5", data); end
  endtask

  initial begin
    test_reset();
    test_update_lookup();
    test_signed_compare();
    test_arbitration();
    test_reset_midflight();
    test_wr_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
